dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
- Multi-channel bus arbiter that hands the shared memory bus from the pipelined CPU to one of N_CH DMA requesters for a bounded burst, then returns it.
- Generalises the single-channel BR/BG grant with fixed 12-cycle counter: parametrised channel count, burst length and arbitration mode, early release, and a mandatory turnaround cycle.
- Sits in the cpu top beside cache/hazard_control; bg/owner outputs drive bus muxing and pipeline stall.

Parameters:
- N_CH, 2, number of DMA requesters (1..8)
- BURST_LEN, 12, maximum granted cycles per burst (2..255)
- ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round robin
- CNT_W, 8, beat counter width; must satisfy 2^CNT_W > BURST_LEN

Ports:
- Clk  in  1  clock; all state changes on posedge
- Reset  in  1  synchronous, active-high reset
- br  in  N_CH  per-channel bus request; level, held until burst done
- cpu_idle  in  1  CPU has no outstanding cache/memory access; bus may be taken
- bg  out  N_CH  one-hot bus grant (all zero when CPU owns bus)
- dma_owns  out  1  OR of bg
- grant_id  out  3  index of granted channel; holds last value when idle
- beat_cnt  out  CNT_W  cycles elapsed in current burst (0 at first grant cycle)
- burst_done  out  1  one-cycle pulse on the cycle after bg falls
- grant_total  out  16  completed-burst counter (see Optional Feature)

Behaviour:
- Reset: state IDLE, bg=0, dma_owns=0, grant_id=0, beat_cnt=0, burst_done=0, grant_total=0, round-robin pointer=0. Reset mid-burst drops bg on that same edge; no burst_done pulse.
- States: IDLE, GRANT, TURN.
- IDLE: if |br and cpu_idle -> GRANT at next edge; bg[winner]=1, grant_id=winner, beat_cnt=0. Otherwise stay. cpu_idle=0 blocks all grants.
- Winner, ARB_MODE 0: lowest-index asserted br.
- Winner, ARB_MODE 1: first asserted br at or after pointer, wrapping modulo N_CH; pointer <= winner+1 (mod N_CH) on grant.
- GRANT: beat_cnt increments each cycle. Leave GRANT when beat_cnt==BURST_LEN-1 (full burst) or br[grant_id]==0 (early release); next edge -> TURN, bg=0.
- Full burst: bg high exactly BURST_LEN cycles (12 by default).
- Early release: bg falls on the edge after br drops.
- Requests on other channels during GRANT are ignored (no preemption).
- TURN: exactly one cycle. burst_done=1, beat_cnt holds its final value, CPU owns the bus. Then -> IDLE.
- Consequence of TURN: back-to-back requests are separated by at least one CPU cycle. The earliest re-grant is the edge after TURN, provided cpu_idle=1.
- Simultaneous br rise and cpu_idle fall in the same cycle: no grant, because cpu_idle is sampled in that cycle.
- br held high through TURN by the same channel is treated as a new request. In RR mode it loses to any other asserted channel.
- bg is always registered, never combinational from br.

Optional Feature:
- Macro DMA_GRANT_STATS_EN.
- Defined: grant_total increments by 1 on every burst_done pulse and saturates at 16'hFFFF. Synchronous Reset clears it.
- Undefined: grant_total tied to 16'h0000; no counter logic is synthesised.

Test Plan:
- Single full burst: N_CH=2, br=2'b01 held, cpu_idle=1. Expect bg=2'b01 for exactly 12 cycles, beat_cnt 0..11, then burst_done pulse for 1 cycle with bg=0.
- Round robin: br=2'b11 held continuously, cpu_idle=1. Expect grants alternating ch0, ch1, ch0, each 12 cycles, with one TURN cycle between grants.
- Fixed priority: ARB_MODE=0, br=2'b11 held. Expect ch0 granted every burst and ch1 never granted.
- Early release: ch1 granted, br[1] dropped when beat_cnt=4. Expect bg falls at the next edge (beat_cnt=5 final), then burst_done pulse.
- CPU busy: br=2'b01, cpu_idle=0 for 7 cycles then 1. Expect no grant while cpu_idle=0; bg rises on the edge after cpu_idle rises.
- Reset mid-burst at beat_cnt=6: expect bg=0, beat_cnt=0, pointer=0 next cycle, no burst_done. With DMA_GRANT_STATS_EN, grant_total=0 after reset and =3 after three full bursts.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// Multi-channel DMA bus arbiter: lends the memory bus from the CPU to one requester for a bounded burst.
// Optional completed-burst statistics counter enabled by defining DMA_GRANT_STATS_EN.
module dma_bus_arbiter #(
    parameter int N_CH      = 2,
    parameter int BURST_LEN = 12,
    parameter int ARB_MODE  = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_CH-1:0]  br_i,
    input  logic             cpu_idle_i,
    output logic [N_CH-1:0]  bg_o,
    output logic             dma_owns_o,
    output logic [2:0]       grant_id_o,
    output logic [CNT_W-1:0] beat_cnt_o,
    output logic             burst_done_o,
    output logic [15:0]      grant_total_o
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   bg_q, bg_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              burst_done_q, burst_done_d;
    logic [2:0]        ptr_q, ptr_d;

    logic [7:0]        br_pad;
    logic [2:0]        win_id;
    logic [N_CH-1:0]   win_onehot;
    logic              req_ok;
    logic              burst_end;

    assign br_pad    = 8'(br_i);
    assign req_ok    = (|br_i) && cpu_idle_i;
    assign burst_end = (state_q == GRANT) &&
                       ((beat_cnt_q == LAST_BEAT) || !br_pad[grant_id_q]);

    generate
        if (ARB_MODE == 0) begin : g_fixed
            always_comb begin
                win_id = '0;
                for (int i = N_CH - 1; i >= 0; i--) begin
                    if (br_i[i]) win_id = 3'(i);
                end
            end
        end else begin : g_rr
            // Scan downward so the asserted request closest to the pointer wins last.
            always_comb begin
                logic [3:0] idx;
                idx    = '0;
                win_id = '0;
                for (int i = N_CH - 1; i >= 0; i--) begin
                    idx = {1'b0, ptr_q} + 4'(i);
                    if (idx >= 4'(N_CH)) idx = idx - 4'(N_CH);
                    if (br_pad[idx[2:0]]) win_id = idx[2:0];
                end
            end
        end
    endgenerate

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
        assign win_onehot[gi] = (win_id == 3'(gi));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // TURN arbitrates like IDLE so a waiting request is re-granted right after the turnaround.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, TURN: state_d = req_ok ? GRANT : IDLE;
            GRANT:      if (burst_end) state_d = TURN;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bg_d         = bg_q;
        grant_id_d   = grant_id_q;
        beat_cnt_d   = beat_cnt_q;
        burst_done_d = 1'b0;
        ptr_d        = ptr_q;
        case (state_q)
            IDLE, TURN: begin
                bg_d = '0;
                if (req_ok) begin
                    bg_d       = win_onehot;
                    grant_id_d = win_id;
                    beat_cnt_d = '0;
                    ptr_d      = (win_id == 3'(N_CH - 1)) ? 3'd0 : win_id + 3'd1;
                end
            end
            GRANT: begin
                if (burst_end) begin
                    bg_d         = '0;
                    burst_done_d = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: bg_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bg_q         <= '0;
            grant_id_q   <= '0;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
            ptr_q        <= '0;
        end else begin
            bg_q         <= bg_d;
            grant_id_q   <= grant_id_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_done_q <= burst_done_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bg_o         = bg_q;
    assign dma_owns_o   = |bg_q;
    assign grant_id_o   = grant_id_q;
    assign beat_cnt_o   = beat_cnt_q;
    assign burst_done_o = burst_done_q;

`ifdef DMA_GRANT_STATS_EN
    logic [15:0] grant_total_q, grant_total_d;

    always_comb begin
        grant_total_d = grant_total_q;
        if (burst_done_q && (grant_total_q != 16'hFFFF))
            grant_total_d = grant_total_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) grant_total_q <= '0;
        else         grant_total_q <= grant_total_d;
    end

    assign grant_total_o = grant_total_q;
`else
    assign grant_total_o = 16'h0000;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: round-robin instance scored against a queue of expected
// bursts, plus a fixed-priority instance checked for channel-0 dominance.
module tb_dma_bus_arbiter;

`ifdef DMA_GRANT_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic       clk = 1'b0;
    logic       srst;
    logic [1:0] br_rr, br_fp;
    logic       cpu_idle;

    logic [1:0]  bg_rr, bg_fp;
    logic        own_rr, own_fp;
    logic [2:0]  gid_rr, gid_fp;
    logic [7:0]  beat_rr, beat_fp;
    logic        done_rr, done_fp;
    logic [15:0] gt_rr, gt_fp;

    always #5 clk = ~clk;

    dma_bus_arbiter #(.N_CH(2), .BURST_LEN(12), .ARB_MODE(1), .CNT_W(8)) dut_rr (
        .clk_i(clk), .reset_i(srst), .br_i(br_rr), .cpu_idle_i(cpu_idle),
        .bg_o(bg_rr), .dma_owns_o(own_rr), .grant_id_o(gid_rr), .beat_cnt_o(beat_rr),
        .burst_done_o(done_rr), .grant_total_o(gt_rr)
    );

    dma_bus_arbiter #(.N_CH(2), .BURST_LEN(12), .ARB_MODE(0), .CNT_W(8)) dut_fp (
        .clk_i(clk), .reset_i(srst), .br_i(br_fp), .cpu_idle_i(cpu_idle),
        .bg_o(bg_fp), .dma_owns_o(own_fp), .grant_id_o(gid_fp), .beat_cnt_o(beat_fp),
        .burst_done_o(done_fp), .grant_total_o(gt_fp)
    );

    typedef struct {
        int id;
        int len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   run   = 0;
    logic [1:0] bg_prev = '0;
    logic seen_ch1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int which, input int val, input string tag);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            case (which)
                0: hit = done_rr;
                1: hit = (int'(beat_rr) == val) && (bg_rr != 2'b00);
                2: hit = (bg_fp != 2'b00);
                default: hit = done_fp;
            endcase
        end
        n_vec++;
        assert (hit) else begin
            n_err++;
            $error("FAIL %s: observed no event in %0d cycles expected event", tag, n);
        end
    endtask

    // Scoreboard for the round-robin instance: one queue entry per expected grant.
    always @(negedge clk) begin
        if (!srst) begin
            check("dma_owns", 32'(own_rr), 32'(|bg_rr));
            if (bg_rr != 2'b00) begin
                if (bg_prev == 2'b00) begin
                    run = 0;
                    n_vec++;
                    assert (exp_q.size() != 0) else begin
                        n_err++;
                        $error("FAIL unexpected_grant: observed bg=%0b expected no grant", bg_rr);
                    end
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    check("grant_bg", 32'(bg_rr), 32'(1) << cur.id);
                    check("grant_id", 32'(gid_rr), 32'(cur.id));
                    $display("grant ch%0d len_expected=%0d t=%0t", gid_rr, cur.len, $time);
                end
                check("beat_cnt", 32'(beat_rr), 32'(run));
                run++;
            end
            if (done_rr) begin
                check("burst_len", 32'(run), 32'(cur.len));
                check("final_beat", 32'(beat_rr), 32'(cur.len - 1));
                check("done_bg", 32'(bg_rr), 32'(0));
            end
        end
        bg_prev = bg_rr;
    end

    always @(negedge clk) if (bg_fp[1]) seen_ch1 = 1'b1;

    initial begin
        srst     = 1'b1;
        br_rr    = 2'b00;
        br_fp    = 2'b00;
        cpu_idle = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bg", 32'(bg_rr), 32'(0));
        check("rst_owns", 32'(own_rr), 32'(0));
        check("rst_gid", 32'(gid_rr), 32'(0));
        check("rst_beat", 32'(beat_rr), 32'(0));
        check("rst_done", 32'(done_rr), 32'(0));
        check("rst_total", 32'(gt_rr), 32'(0));
        srst = 1'b0;
        @(negedge clk);

        // Single full burst on channel 0.
        exp_q.push_back('{0, 12});
        br_rr = 2'b01;
        wait_until(0, 0, "full_burst_done");
        br_rr = 2'b00;
        repeat (2) @(negedge clk);

        // Round robin with both held: pointer is 1 after the previous grant.
        exp_q.push_back('{1, 12});
        exp_q.push_back('{0, 12});
        exp_q.push_back('{1, 12});
        br_rr = 2'b11;
        wait_until(0, 0, "rr_done0");
        @(negedge clk);
        check("rr_turn_regrant0", 32'(bg_rr), 32'(2'b01));
        wait_until(0, 0, "rr_done1");
        @(negedge clk);
        check("rr_turn_regrant1", 32'(bg_rr), 32'(2'b10));
        wait_until(0, 0, "rr_done2");
        br_rr = 2'b00;
        repeat (2) @(negedge clk);

        // Early release of channel 1 as its beat counter leaves 4.
        exp_q.push_back('{1, 6});
        br_rr = 2'b10;
        wait_until(1, 4, "early_beat4");
        @(posedge clk);
        #1 br_rr = 2'b00;
        wait_until(0, 0, "early_done");
        repeat (2) @(negedge clk);

        // CPU busy: request and cpu_idle fall arrive together; no grant until cpu_idle returns.
        br_rr    = 2'b01;
        cpu_idle = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("busy_no_grant", 32'(bg_rr), 32'(0));
        end
        exp_q.push_back('{0, 12});
        cpu_idle = 1'b1;
        @(negedge clk);
        check("busy_grant", 32'(bg_rr), 32'(2'b01));
        wait_until(0, 0, "busy_done");
        br_rr = 2'b00;
        repeat (2) @(negedge clk);
        check("total_after6", 32'(gt_rr), 32'(STATS * 6));

        // Reset in the middle of a burst.
        exp_q.push_back('{0, 12});
        br_rr = 2'b01;
        wait_until(1, 6, "reset_beat6");
        srst = 1'b1;
        @(negedge clk);
        check("mid_rst_bg", 32'(bg_rr), 32'(0));
        check("mid_rst_beat", 32'(beat_rr), 32'(0));
        check("mid_rst_done", 32'(done_rr), 32'(0));
        check("mid_rst_total", 32'(gt_rr), 32'(0));

        // Pointer back at 0: both held -> 0,1,0.
        exp_q.push_back('{0, 12});
        exp_q.push_back('{1, 12});
        exp_q.push_back('{0, 12});
        srst  = 1'b0;
        br_rr = 2'b11;
        @(negedge clk);
        check("post_rst_done", 32'(done_rr), 32'(0));
        wait_until(0, 0, "post_rst_done0");
        wait_until(0, 0, "post_rst_done1");
        wait_until(0, 0, "post_rst_done2");
        br_rr = 2'b00;
        repeat (2) @(negedge clk);
        check("total_after3", 32'(gt_rr), 32'(STATS * 3));
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        // Fixed priority: channel 0 wins every burst.
        br_fp = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_until(2, 0, "fp_grant");
            check("fp_bg", 32'(bg_fp), 32'(2'b01));
            check("fp_gid", 32'(gid_fp), 32'(0));
            check("fp_owns", 32'(own_fp), 32'(1));
            $display("fp grant %0d ch%0d t=%0t", k, gid_fp, $time);
            wait_until(3, 0, "fp_done");
        end
        check("fp_ch1_never", 32'(seen_ch1), 32'(0));
        repeat (2) @(negedge clk);
        check("fp_total", 32'(gt_fp), 32'(STATS * 3));
        br_fp = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
